// File: rtl/cb_cfg_if.sv
// cb_cfg_if: one valid/ready word link in the configuration bitstream chain.
//   valid  master->slave  word present
//   data   master->slave  DW-bit bitstream word
//   ready  slave->master  slave takes the word when valid & ready at posedge
interface cb_cfg_if #(
  parameter int DW = 8
);
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/cb_config_loader.sv
// cb_config_loader: per-tile configuration loader for a connection block.
// Shifts its own NW words from the chain into a shadow register. After that,
// every later word goes to the next tile through a one-stage register.
// A commit pulse copies the shadow into the active control vector c.
// Ports:
//   clk, rst_n  configuration clock, async active-low reset
//   cfg_en      configuration mode; low flushes the loader back to IDLE
//   up          upstream word link (slave side: drives ready)
//   dn          downstream word link (master side: registered valid/data)
//   commit      one-cycle pulse, shadow -> c
//   c           active connection-block control bits
//   loaded      c holds a complete committed image
//   cfg_err     sticky: commit arrived while the shadow was incomplete
module cb_config_loader #(
  parameter int CFG_W = 248,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  cb_cfg_if.slave          up,
  cb_cfg_if.master         dn,
  input  logic             commit,
  output logic [CFG_W-1:0] c,
  output logic             loaded,
  output logic             cfg_err
);
  localparam int NW = CFG_W / DW;
  localparam int CW = $clog2(NW + 1);

  if (CFG_W % DW != 0) begin : g_bad_cfg
    $error("cb_config_loader: CFG_W must be a multiple of DW");
  end

  typedef enum logic [1:0] {IDLE, LOAD, PASS} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [CFG_W-1:0] shadow, shadow_n;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             in_ready, accept, last_word;

  assign up.ready = in_ready;
  assign dn.valid = out_valid;
  assign dn.data  = out_data;
  assign accept   = up.valid & in_ready;

  // New words enter at the top, so word k ends up at shadow[k*DW +: DW].
  assign shadow_n = {up.data, shadow[CFG_W-1:DW]};

  // The word that completes this tile's image. A commit on the same edge
  // must see the image with this word already in it.
  assign last_word = cfg_en & (state == LOAD) & accept & (cnt == CW'(NW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // in_ready depends only on state and the output stage. It never depends on
  // in_valid, so no combinational loop can form along the chain.
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    case (state)
      IDLE: if (cfg_en) state_n = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (last_word) state_n = PASS;
      end
      PASS: in_ready = !out_valid | dn.ready;
      default: state_n = IDLE;
    endcase
    if (!cfg_en) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      shadow    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      c         <= '0;
      loaded    <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (!cfg_en) begin
        // Flush. A word still in the output stage is discarded with the pass.
        cnt       <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          LOAD: if (accept) begin
            shadow <= shadow_n;
            cnt    <= last_word ? '0 : cnt + CW'(1);
          end
          PASS: begin
            if (accept) begin
              out_data  <= up.data;
              out_valid <= 1'b1;
            end else if (dn.ready) begin
              out_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      if (state == IDLE && cfg_en) cfg_err <= 1'b0;

      // c changes only here, so the fabric never sees a partial image.
      if (commit) begin
        if (state == PASS) begin
          c      <= shadow;
          loaded <= 1'b1;
        end else if (last_word) begin
          c      <= shadow_n;
          loaded <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cb_config_loader.sv
// Bench for cb_config_loader. Directed vectors drive the loader. A scoreboard
// queue holds the words expected downstream, and a separate monitor checks
// each word when it leaves the output stage.
module tb_cb_config_loader;
  localparam int CFG_W = 248;
  localparam int DW    = 8;
  localparam int NW    = CFG_W / DW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_en = 1'b0;
  logic             commit = 1'b0;
  logic [CFG_W-1:0] c;
  logic             loaded, cfg_err;
  logic             tog_en = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] sb_q[$];

  cb_cfg_if #(.DW(DW)) up ();
  cb_cfg_if #(.DW(DW)) dn ();

  cb_config_loader #(.CFG_W(CFG_W), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_en  (cfg_en),
    .up      (up),
    .dn      (dn),
    .commit  (commit),
    .c       (c),
    .loaded  (loaded),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [CFG_W-1:0] act, input logic [CFG_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Image whose word k is base+k.
  function automatic logic [CFG_W-1:0] img(input int base);
    logic [CFG_W-1:0] v;
    v = '0;
    for (int k = 0; k < NW; k++) v[k*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  // Monitor: a transfer happens at the next posedge when valid & ready.
  always @(negedge clk) begin
    if (rst_n && dn.valid && dn.ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL chain_extra: got %h want none", dn.data);
      end else begin
        chk("chain_data", CFG_W'(dn.data), CFG_W'(sb_q.pop_front()));
      end
    end
  end

  task automatic tick();
    if (tog_en) dn.ready = ~dn.ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic cm, input logic push);
    logic rdy;
    int   n;
    n = 0;
    up.valid = 1'b1;
    up.data  = d;
    commit   = cm;
    do begin
      if (tog_en) dn.ready = ~dn.ready;
      #1;
      rdy = up.ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 100);
    up.valid = 1'b0;
    commit   = 1'b0;
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no ready want ready for word %h", d);
    end else if (push) begin
      sb_q.push_back(d);
    end
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0;
  endtask

  task automatic reenter();
    cfg_en = 1'b0;
    idle(1);
    cfg_en = 1'b1;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    up.valid = 1'b0;
    up.data  = '0;
    dn.ready = 1'b1;

    // Reset state
    #12;
    chk("rst_c", c, '0);
    chk("rst_loaded", CFG_W'(loaded), '0);
    chk("rst_err", CFG_W'(cfg_err), '0);
    chk("rst_out_valid", CFG_W'(dn.valid), '0);
    chk("rst_in_ready", CFG_W'(up.ready), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T2: full load 0x00..0x1E then commit
    cfg_en = 1'b1;
    for (int k = 0; k < NW; k++) send_word(DW'(k), 1'b0, 1'b0);
    do_commit();
    chk("t2_c_lo", CFG_W'(c[7:0]), CFG_W'(8'h00));
    chk("t2_c_hi", CFG_W'(c[247:240]), CFG_W'(8'h1E));
    chk("t2_c", c, img(0));
    chk("t2_loaded", CFG_W'(loaded), CFG_W'(1'b1));
    chk("t2_err", CFG_W'(cfg_err), '0);

    // T3: pass-through with out_ready toggling 1,0,1,0
    dn.ready = 1'b0;
    tog_en   = 1'b1;
    for (int k = 0; k < 5; k++) send_word(DW'(8'hA0 + k), 1'b0, 1'b1);
    idle(6);
    tog_en   = 1'b0;
    dn.ready = 1'b1;
    idle(3);
    chk("t3_drained", CFG_W'(sb_q.size()), '0);
    chk("t3_c", c, img(0));

    // T4: early commit, then complete the load and commit
    reenter();
    for (int k = 0; k < 10; k++) send_word(DW'(8'h40 + k), 1'b0, 1'b0);
    do_commit();
    chk("t4_err", CFG_W'(cfg_err), CFG_W'(1'b1));
    chk("t4_c_kept", c, img(0));
    chk("t4_loaded", CFG_W'(loaded), CFG_W'(1'b1));
    for (int k = 10; k < NW; k++) send_word(DW'(8'h40 + k), 1'b0, 1'b0);
    do_commit();
    chk("t4_c_new", c, img(8'h40));
    chk("t4_err_sticky", CFG_W'(cfg_err), CFG_W'(1'b1));
    reenter();
    chk("t4_err_clr", CFG_W'(cfg_err), '0);

    // T5: commit on the same edge as the last word (0x5A)
    for (int k = 0; k < NW - 1; k++) send_word(DW'(8'h3C + k), 1'b0, 1'b0);
    send_word(8'h5A, 1'b1, 1'b0);
    chk("t5_c_hi", CFG_W'(c[247:240]), CFG_W'(8'h5A));
    chk("t5_c", c, img(8'h3C));
    chk("t5_loaded", CFG_W'(loaded), CFG_W'(1'b1));
    chk("t5_err", CFG_W'(cfg_err), '0);

    // T6: abort after 12 words, then a fresh full image
    reenter();
    for (int k = 0; k < 12; k++) send_word(DW'(8'h80 + k), 1'b0, 1'b0);
    cfg_en = 1'b0;
    idle(1);
    chk("t6_idle_ready", CFG_W'(up.ready), '0);
    chk("t6_c_kept", c, img(8'h3C));
    cfg_en = 1'b1;
    idle(1);
    for (int k = 0; k < NW; k++) send_word(DW'(8'hC0 + k), 1'b0, 1'b0);
    do_commit();
    chk("t6_c_new", c, img(8'hC0));
    chk("t6_err", CFG_W'(cfg_err), '0);

    // T1: async reset while in PASS with a word held in the output stage
    dn.ready = 1'b0;
    send_word(8'h77, 1'b0, 1'b0);
    chk("t1_pre_valid", CFG_W'(dn.valid), CFG_W'(1'b1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("t1_c", c, '0);
    chk("t1_loaded", CFG_W'(loaded), '0);
    chk("t1_out_valid", CFG_W'(dn.valid), '0);
    chk("t1_in_ready", CFG_W'(up.ready), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
